data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, handshaked data memory for the MIPS datapath. It is the next generation of the single-port word data memory.
- Adds byte/halfword/word access with sign or zero extension, alignment checking, and configurable wait states.
- Adds hardware zero-initialisation after reset.
- Sits between the core's load/store unit and a local word-organised RAM array.

Parameters:
- ADDR_W, 6: word-address bits; depth = 2**ADDR_W 32-bit words; byte address is ADDR_W+2 bits.
- WAIT_STATES, 0: extra cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or illegal-size request; qualified by resp_valid
- init_done  out  1  memory zeroing complete

Behaviour:
- Reset:
  - Reset is synchronous and active-low: sampled only on the rising clk edge while reset_n=0. Clock is clk.
  - Reset values: state=INIT, init counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, init_done=0.
- INIT state:
  - Writes 0 to word[counter], one word per cycle, counter 0..2**ADDR_W-1.
  - After the last word: init_done=1 (stays 1 until the next reset), go to IDLE.
  - The first IDLE cycle is 2**ADDR_W cycles after reset release.
- IDLE state:
  - req_ready=1.
  - Accept on req_valid&&req_ready at cycle T.
  - Latch write, size, unsigned, addr and wdata.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT state:
  - req_ready=0.
  - Down-counter loaded with WAIT_STATES-1 at accept; leave for RESP when it reaches 0.
- RESP state:
  - resp_valid=1 in cycle T+1+WAIT_STATES, for exactly one cycle.
  - Next state is IDLE.
  - No back-pressure on the response; req_ready=0 during RESP.
  - Throughput: one request per WAIT_STATES+2 cycles.
- Store commit and read sampling:
  - Stores commit to the array on the same edge that raises resp_valid.
  - Loads sample the array on that edge.
  - A load accepted after a store's response therefore always returns the new data.
- Byte order: little-endian; byte lane k = bits [8k+7:8k]; lane select = addr[1:0]; word index = addr[ADDR_W+1:2].
- Stores:
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes addr[1]*2 and +1 <= wdata[15:0].
  - Word: all lanes.
  - Unselected lanes are unchanged.
- Loads:
  - The selected byte or half is right-justified.
  - Sign-extended from bit 7/15 unless req_unsigned=1.
  - Word loads ignore req_unsigned.
- Alignment checking:
  - Misaligned cases: half with addr[0]=1; word with addr[1:0]!=0; size 11 is illegal.
  - Result: no array write, resp_error=1, resp_rdata=0.
  - Latency is the same as a normal access.
- resp_rdata and resp_error hold their values after the pulse until the next response.
- Reset mid-operation (any state): the in-flight request is dropped, no resp_valid, array re-zeroed via INIT.
- req_valid while not ready: ignored. The requester holds it; no request is queued.

Decomposition:
- Package dmem_pkg:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - State enum INIT/IDLE/WAIT/RESP.
  - Function is_misaligned(size, addr[1:0]).
- Sub-module dmem_lane_align, combinational:
  - Inputs: size, addr[1:0], unsigned, wdata, raw word.
  - Outputs: 4-bit byte-enable, lane-steered write word, extended load data.
- The top module holds the FSM, counters and array.

Test Plan:
- Init (ADDR_W=6, WAIT_STATES=0):
  - Release reset -> init_done and req_ready rise exactly 64 cycles later.
  - LW of every address returns 0x00000000 with resp_error=0.
- Sub-word store and signed load:
  - SW 0x11223344 @0x10 -> response 1 cycle after accept.
  - SB 0xAA @0x11 -> LW @0x10 = 0x1122AA44.
  - LB @0x11 = 0xFFFFFFAA; LBU @0x11 = 0x000000AA.
- Halfword:
  - SH 0x8001 @0x22 -> LW @0x20 = 0x80010000.
  - LH @0x22 = 0xFFFF8001; LHU = 0x00008001.
- Misalignment:
  - LW @0x06 -> resp_error=1, rdata=0.
  - SH @0x21 -> resp_error=1, memory unchanged.
  - size=11 -> resp_error=1.
- Latency/handshake (WAIT_STATES=3):
  - Accept at cycle T -> req_ready=0 for T+1..T+4; resp_valid only at T+4.
  - Back-to-back requests accepted every 5 cycles.
- Reset mid-op:
  - Accept SW 0xDEADBEEF @0x08 with WAIT_STATES=3; assert reset_n=0 in WAIT.
  - Expect no resp_valid and init restarts.
  - Afterwards LW @0x08 = 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the alignment rule used by both the datapath and the FSM.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dmem_state_e;

  // Illegal size counts as misaligned so both error causes share one path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r_mis;
    case (size)
      SIZE_BYTE: r_mis = 1'b0;
      SIZE_HALF: r_mis = addr_lo[0];
      SIZE_WORD: r_mis = (addr_lo != 2'b00);
      default:   r_mis = 1'b1;
    endcase
    return r_mis;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_lane_align.sv
// Little-endian lane steering: byte enables and replicated write data for
// stores, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_raw[7:0];
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
  end

  // Write data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    o_be    = 4'b0000;
    o_wword = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      end
      SIZE_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
      end
      SIZE_WORD: begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        o_rdata = i_raw;
      end
      default: begin
        o_be    = 4'b0000;
        o_wword = 32'h0;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked byte/half/word data memory with wait states, alignment checking
// and zero-initialisation of the array after every reset.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              init_done,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with
  // no back-pressure. req_valid seen while req_ready is low is ignored.

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e       r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [3:0]        r_wait_cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_access;
  logic              w_op_write;
  logic [1:0]        w_op_size;
  logic              w_op_unsigned;
  logic [ADDR_W+1:0] w_op_addr;
  logic [31:0]       w_op_wdata;
  logic [ADDR_W-1:0] w_word_idx;
  logic [31:0]       w_raw;
  logic              w_err;
  logic              w_store;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic [31:0]       w_rdata;

  assign w_accept = req_valid && req_ready;

  // With no wait states the array access happens on the accept edge itself,
  // so the live request fields are used; otherwise the latched copy.
  assign w_op_write    = (r_state == ST_IDLE) ? req_write    : r_write;
  assign w_op_size     = (r_state == ST_IDLE) ? req_size     : r_size;
  assign w_op_unsigned = (r_state == ST_IDLE) ? req_unsigned : r_unsigned;
  assign w_op_addr     = (r_state == ST_IDLE) ? req_addr     : r_addr;
  assign w_op_wdata    = (r_state == ST_IDLE) ? req_wdata    : r_wdata;

  assign w_access   = (WAIT_STATES == 0) ? w_accept
                                         : ((r_state == ST_WAIT) && (r_wait_cnt == 4'd0));
  assign w_word_idx = w_op_addr[ADDR_W+1:2];
  assign w_raw      = r_mem[w_word_idx];
  assign w_err      = is_misaligned(w_op_size, w_op_addr[1:0]);
  assign w_store    = w_access && w_op_write && !w_err;

  dmem_lane_align u_lane_align (
    .i_size     (w_op_size),
    .i_addr_lo  (w_op_addr[1:0]),
    .i_unsigned (w_op_unsigned),
    .i_wdata    (w_op_wdata),
    .i_raw      (w_raw),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_init_cnt] <= 32'h0;
      end else if (w_store) begin
        for (int k = 0; k < 4; k++) begin
          if (w_be[k]) r_mem[w_word_idx][8*k +: 8] <= w_wword[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (w_access) begin
        resp_valid <= 1'b1;
        resp_error <= w_err;
        resp_rdata <= (w_err || w_op_write) ? 32'h0 : w_rdata;
      end
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (&r_init_cnt) begin
            r_state   <= ST_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) r_state <= ST_RESP;
          else                    r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: instance A has no wait states, instance
// B has three; vectors run on A, handshake and reset corner cases on B.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, va, ready_a, wa, ua, rv_a, err_a, id_a;
  logic [1:0]  sa, st_a;
  logic [7:0]  addr_a;
  logic [31:0] wd_a, rd_a;
  logic        rst_b_n, vb, ready_b, wb, ub, rv_b, err_b, id_b;
  logic [1:0]  sb, st_b;
  logic [7:0]  addr_b;
  logic [31:0] wd_b, rd_b;

  data_memory_ctrl #(.ADDR_W(6), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .req_valid(va), .req_ready(ready_a), .req_write(wa),
    .req_size(sa), .req_unsigned(ua), .req_addr(addr_a), .req_wdata(wd_a),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_error(err_a), .init_done(id_a),
    .o_dbg_state(st_a)
  );

  data_memory_ctrl #(.ADDR_W(6), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .req_valid(vb), .req_ready(ready_b), .req_write(wb),
    .req_size(sb), .req_unsigned(ub), .req_addr(addr_b), .req_wdata(wd_b),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_error(err_b), .init_done(id_b),
    .o_dbg_state(st_b)
  );

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [7:0]  ad;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic w, input logic [1:0] sz, input logic u,
                         input logic [7:0] ad, input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err);
    vec_t v;
    v.name = name; v.w = w; v.sz = sz; v.u = u; v.ad = ad; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sel, input logic v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [7:0] ad, input logic [31:0] wd);
    if (!sel) begin va = v; wa = w; sa = sz; ua = u; addr_a = ad; wd_a = wd; end
    else      begin vb = v; wb = w; sb = sz; ub = u; addr_b = ad; wd_b = wd; end
  endtask

  function automatic logic ready_of(input bit sel); return sel ? ready_b : ready_a; endfunction
  function automatic logic rv_of(input bit sel);    return sel ? rv_b : rv_a;       endfunction

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic do_req(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                        input logic [7:0] ad, input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat, output int ready_low);
    int n;
    @(negedge clk);
    drive(sel, 1'b1, w, sz, u, ad, wd);
    n = 0;
    while (!ready_of(sel) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("req_ready_timeout", 32'(ready_of(sel)), 32'd1);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    lat = 1; ready_low = 0;
    while (!rv_of(sel) && lat < 50) begin
      if (!ready_of(sel)) ready_low++;
      @(negedge clk);
      lat++;
    end
    if (!ready_of(sel)) ready_low++;
    rd = sel ? rd_b : rd_a;
    er = sel ? err_b : err_a;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, rlow, first_a, first_b, acc, c, nresp, seen;
    int          acc_cyc [3];

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_valid_a", 32'(rv_a), 32'd0);
    check("rst_rdata_a", rd_a, 32'h0);
    check("rst_error_a", 32'(err_a), 32'd0);
    check("rst_init_done_a", 32'(id_a), 32'd0);
    check("rst_state_a", 32'(st_a), 32'(ST_INIT));
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_init_done_b", 32'(id_b), 32'd0);

    // Init latency: both instances leave INIT 64 edges after release.
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    first_a = -1; first_b = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (id_a && first_a < 0) first_a = k;
      if (id_b && first_b < 0) first_b = k;
      if (k == 63) check("ready_before_init_a", 32'(ready_a), 32'd0);
    end
    check("init_latency_a", 32'(first_a), 32'd64);
    check("init_latency_b", 32'(first_b), 32'd64);
    check("ready_after_init_a", 32'(ready_a), 32'd1);
    check("state_idle_a", 32'(st_a), 32'(ST_IDLE));

    for (int i = 0; i < 64; i++) begin
      do_req(1'b0, 1'b0, SIZE_WORD, 1'b0, 8'(i * 4), 32'h0, rd, er, lat, rlow);
      check($sformatf("init_zero_rd_%0d", i), rd, 32'h0);
      check($sformatf("init_zero_err_%0d", i), 32'(er), 32'd0);
    end

    add_vec("sw_word",         1, SIZE_WORD, 0, 8'h10, 32'h11223344, 32'h0,        0);
    add_vec("sb_lane1",        1, SIZE_BYTE, 0, 8'h11, 32'h000000AA, 32'h0,        0);
    add_vec("lw_after_sb",     0, SIZE_WORD, 0, 8'h10, 32'h0,        32'h1122AA44, 0);
    add_vec("lb_signed",       0, SIZE_BYTE, 0, 8'h11, 32'h0,        32'hFFFFFFAA, 0);
    add_vec("lbu",             0, SIZE_BYTE, 1, 8'h11, 32'h0,        32'h000000AA, 0);
    add_vec("lb_positive",     0, SIZE_BYTE, 0, 8'h10, 32'h0,        32'h00000044, 0);
    add_vec("lbu_lane3",       0, SIZE_BYTE, 1, 8'h13, 32'h0,        32'h00000011, 0);
    add_vec("lh_lo_signed",    0, SIZE_HALF, 0, 8'h10, 32'h0,        32'hFFFFAA44, 0);
    add_vec("lhu_hi",          0, SIZE_HALF, 1, 8'h12, 32'h0,        32'h00001122, 0);
    add_vec("sh_hi",           1, SIZE_HALF, 0, 8'h22, 32'h00008001, 32'h0,        0);
    add_vec("lw_after_sh",     0, SIZE_WORD, 0, 8'h20, 32'h0,        32'h80010000, 0);
    add_vec("lh_signed",       0, SIZE_HALF, 0, 8'h22, 32'h0,        32'hFFFF8001, 0);
    add_vec("lhu",             0, SIZE_HALF, 1, 8'h22, 32'h0,        32'h00008001, 0);
    add_vec("lh_lo_zero",      0, SIZE_HALF, 0, 8'h20, 32'h0,        32'h0,        0);
    add_vec("lw_misaligned",   0, SIZE_WORD, 0, 8'h06, 32'h0,        32'h0,        1);
    add_vec("lw_mis_nonzero",  0, SIZE_WORD, 0, 8'h11, 32'h0,        32'h0,        1);
    add_vec("lh_misaligned",   0, SIZE_HALF, 0, 8'h23, 32'h0,        32'h0,        1);
    add_vec("sh_misaligned",   1, SIZE_HALF, 0, 8'h21, 32'h00001234, 32'h0,        1);
    add_vec("lw_sh_unchanged", 0, SIZE_WORD, 0, 8'h20, 32'h0,        32'h80010000, 0);
    add_vec("sw_misaligned",   1, SIZE_WORD, 0, 8'h0E, 32'hFFFFFFFF, 32'h0,        1);
    add_vec("lw_sw_unchanged", 0, SIZE_WORD, 0, 8'h0C, 32'h0,        32'h0,        0);
    add_vec("ld_size11",       0, SIZE_ILL,  0, 8'h30, 32'h0,        32'h0,        1);
    add_vec("st_size11",       1, SIZE_ILL,  0, 8'h30, 32'hFFFFFFFF, 32'h0,        1);
    add_vec("lw_size11_unch",  0, SIZE_WORD, 0, 8'h30, 32'h0,        32'h0,        0);
    add_vec("sb_last",         1, SIZE_BYTE, 0, 8'hFF, 32'hABCDEF80, 32'h0,        0);
    add_vec("lw_last",         0, SIZE_WORD, 0, 8'hFC, 32'h0,        32'h80000000, 0);
    add_vec("lb_last",         0, SIZE_BYTE, 0, 8'hFF, 32'h0,        32'hFFFFFF80, 0);
    add_vec("lw_uns_ignored",  0, SIZE_WORD, 1, 8'h10, 32'h0,        32'h1122AA44, 0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_rd);
      do_req(1'b0, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].ad, vecs[i].wd, rd, er, lat, rlow);
      check({vecs[i].name, "_rdata"}, rd, exp_q.pop_front());
      check({vecs[i].name, "_error"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd1);
    end

    // Pulse is one cycle wide and the data holds afterwards.
    do_req(1'b0, 1'b0, SIZE_WORD, 1'b0, 8'h10, 32'h0, rd, er, lat, rlow);
    @(negedge clk);
    check("pulse_width_a", 32'(rv_a), 32'd0);
    check("rdata_hold_a", rd_a, 32'h1122AA44);
    check("ready_back_a", 32'(ready_a), 32'd1);

    // Wait-state instance: latency and ready-low window.
    do_req(1'b1, 1'b1, SIZE_WORD, 1'b0, 8'h04, 32'hCAFEF00D, rd, er, lat, rlow);
    check("b_store_latency", 32'(lat), 32'd4);
    check("b_ready_low_cycles", 32'(rlow), 32'd4);
    @(negedge clk);
    check("b_ready_after_resp", 32'(ready_b), 32'd1);
    check("b_pulse_width", 32'(rv_b), 32'd0);

    // Back-to-back loads with req_valid held high.
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, SIZE_WORD, 1'b0, 8'h04, 32'h0);
    acc = 0; c = 0; nresp = 0;
    while (acc < 3 && c < 60) begin
      if (ready_b) begin acc_cyc[acc] = c; acc++; end
      @(negedge clk);
      c++;
      if (rv_b) nresp++;
    end
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    while (nresp < 3 && c < 80) begin @(negedge clk); c++; if (rv_b) nresp++; end
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
    check("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    check("b2b_responses", 32'(nresp), 32'd3);
    check("b2b_rdata", rd_b, 32'hCAFEF00D);

    // Reset during WAIT drops the store and re-zeroes the array.
    do_req(1'b1, 1'b1, SIZE_WORD, 1'b0, 8'h08, 32'h12345678, rd, er, lat, rlow);
    do_req(1'b1, 1'b0, SIZE_WORD, 1'b0, 8'h08, 32'h0, rd, er, lat, rlow);
    check("b_pre_reset_value", rd, 32'h12345678);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, SIZE_WORD, 1'b0, 8'h08, 32'hDEADBEEF);
    c = 0;
    while (!ready_b && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    check("midop_state_wait", 32'(st_b), 32'(ST_WAIT));
    rst_b_n = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (rv_b) seen++; end
    check("midop_init_done_low", 32'(id_b), 32'd0);
    check("midop_state_init", 32'(st_b), 32'(ST_INIT));
    rst_b_n = 1'b1;
    first_b = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (rv_b) seen++;
      if (id_b && first_b < 0) first_b = k;
    end
    check("midop_no_resp", 32'(seen), 32'd0);
    check("midop_reinit_latency", 32'(first_b), 32'd64);
    do_req(1'b1, 1'b0, SIZE_WORD, 1'b0, 8'h08, 32'h0, rd, er, lat, rlow);
    check("midop_lw_zero", rd, 32'h0);
    check("midop_lw_err", 32'(er), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
